pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
- Consumer end of the branch-control interface. Takes the 2-bit branch decision resolved in EX, owns the program counter and drives the fetch request.
- Generates the IF/ID and ID/EX flush pulses that squash wrong-path instructions.
- Arbitrates between sequential fetch, taken branch/JAL, JALR, load-use stall and instruction-memory back-pressure.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the redirect performance counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- branch_ctrl  input  2  from EX stage: 00 sequential, 01 PC-relative target (branch taken/JAL), 10 JALR target, 11 reserved.
- ex_valid  input  1  EX holds a real (non-bubble) instruction; branch_ctrl is ignored when low.
- ex_pc  input  32  PC of the instruction in EX.
- ex_imm  input  32  sign-extended immediate of the EX instruction.
- jalr_target  input  32  ALU result for JALR (rs1+imm).
- hazard_stall  input  1  load-use stall from the hazard unit; freezes PC and IF/ID.
- imem_ready  input  1  instruction memory accepts/returns the current request this cycle.
- pc  output  32  current fetch address.
- imem_req  output  1  fetch request valid.
- pc_write  output  1  PC advances or reloads at this edge (diagnostic).
- flush_ifid  output  1  clear IF/ID at this edge.
- flush_idex  output  1  clear ID/EX at this edge.
- misalign_err  output  1  one-cycle pulse when the redirect target has bit[1] set.
- redirect_cnt  output  CNT_W  count of accepted redirects, saturating.

Behaviour:
- Reset (rst=1 at an edge):
  - Sets pc=RESET_PC, state=BOOT and redirect_cnt=0.
  - All pulse outputs are 0 during and after the reset cycle.
  - Reset mid-operation discards any pending redirect.
- States: BOOT, RUN, WAIT.
  - BOOT: imem_req=0 for exactly one cycle, then RUN unconditionally.
  - RUN: imem_req=1. If imem_ready=0 and no redirect, go to WAIT and hold pc.
  - WAIT: imem_req=1 and pc held. Return to RUN on imem_ready=1. A redirect in WAIT also returns to RUN.
- Redirect condition: take = ex_valid & (branch_ctrl==01 | branch_ctrl==10). Value 11 is treated as 00.
- Target calculation (32-bit, wrap modulo 2^32, no overflow detection):
  - branch_ctrl=01: target = ex_pc+ex_imm.
  - branch_ctrl=10: target = {jalr_target[31:1],1'b0}.
- Priority, highest first: rst > take > hazard_stall > imem back-pressure > sequential.
- take=1 in any non-BOOT state:
  - flush_ifid=1 and flush_idex=1 combinationally in the same cycle.
  - pc<=target at the edge; pc_write=1.
  - redirect_cnt increments, saturating at all-ones.
  - Overrides hazard_stall and imem_ready=0.
  - A fetch completing in the same cycle is squashed by flush_ifid.
- take=1 in BOOT: the PC is not touched and no flush occurs, because EX holds only reset bubbles.
- hazard_stall=1 without take: pc held, pc_write=0, no flush. imem_req stays 1 and the refetch of the same pc is accepted.
- Sequential advance (no take, no stall, RUN, imem_ready=1): pc<=pc+4, pc_write=1.
- misalign_err: pulses with take whenever target[1]=1. The redirect still happens; trap handling lives elsewhere.
- Back-to-back redirects on consecutive cycles are each honoured; the second target wins.
- Latency: redirect decision to new pc on the bus is 1 cycle; fetch penalty is 2 squashed instructions.

Decomposition:
- Shared package holds:
  - branch_ctrl encodings (BR_SEQ=2'b00, BR_PCREL=2'b01, BR_JALR=2'b10).
  - State encodings BOOT/RUN/WAIT.
  - The constant 32'd4.
  - RESET_PC default.
- One natural sub-module, pc_target_calc: a combinational adder/mux producing target and misalign from branch_ctrl, ex_pc, ex_imm and jalr_target.

Test Plan:
- Reset hold: rst=1 for 3 cycles, then release with imem_ready=1. Expect pc=0 and imem_req=0 for one cycle, then pc=0,4,8,C on successive cycles with flush_* always 0.
- Taken branch: in RUN at pc=0x20, apply ex_valid=1, branch_ctrl=01, ex_pc=0x18, ex_imm=0xFFFF_FFF0. Expect flush_ifid=flush_idex=1 that cycle, pc=0x08 next cycle, redirect_cnt=1.
- JALR alignment: branch_ctrl=10, jalr_target=0x0000_1003. Expect pc=0x0000_1002 next cycle and misalign_err=1 for one cycle.
- Stall vs redirect: hazard_stall=1 for 2 cycles at pc=0x40, with take (01, ex_pc=0x38, ex_imm=0x100) in the second cycle. Expect pc held at 0x40 in the first cycle, then pc=0x138 with both flushes asserted.
- Back-pressure: imem_ready=0 for 3 cycles at pc=0x10. Expect state WAIT, pc=0x10 held and imem_req=1; after ready returns, pc=0x14. Repeat with take in the middle of WAIT: expect an immediate reload to the target.
- Ignored encodings: branch_ctrl=11 with ex_valid=1, and branch_ctrl=01 with ex_valid=0. Expect sequential pc+4, no flush and redirect_cnt unchanged.

Source files
------------

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared encodings and constants for the PC redirect controller.
// Used by the target calculator and the top-level controller.
package pc_redirect_ctrl_pkg;

   localparam logic [1:0]  BR_SEQ       = 2'b00;
   localparam logic [1:0]  BR_PCREL     = 2'b01;
   localparam logic [1:0]  BR_JALR      = 2'b10;

   localparam logic [31:0] PC_STEP      = 32'd4;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] target;
      logic        misalign;
   } tgt_t;

   // 2'b11 is reserved and behaves like sequential fetch.
   function automatic logic is_redirect(input logic [1:0] bc);
      return (bc == BR_PCREL) || (bc == BR_JALR);
   endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target adder/mux: PC-relative sum or JALR result with bit 0 cleared.
// Flags targets that are not word aligned (bit 1 set).
module pc_target_calc
   import pc_redirect_ctrl_pkg::*;
(
   input  logic [1:0]  branch_ctrl,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_imm,
   input  logic [31:0] jalr_target,
   output tgt_t        tgt
);

   logic [31:0] target;

   always_comb begin
      target = ex_pc + ex_imm;
      if (branch_ctrl == BR_JALR)
         target = {jalr_target[31:1], 1'b0};
   end

   assign tgt.target   = target;
   assign tgt.misalign = target[1];

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Program counter owner: sequential fetch, branch/JALR redirect, load-use stall
// and instruction-memory back-pressure, plus the wrong-path flush pulses.
module pc_redirect_ctrl
   import pc_redirect_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       branch_ctrl,
   input  logic             ex_valid,
   input  logic [31:0]      ex_pc,
   input  logic [31:0]      ex_imm,
   input  logic [31:0]      jalr_target,
   input  logic             hazard_stall,
   input  logic             imem_ready,
   output logic [31:0]      pc,
   output logic             imem_req,
   output logic             pc_write,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             misalign_err,
   output logic [CNT_W-1:0] redirect_cnt
);

   state_t state, state_nxt;
   tgt_t   tgt;
   logic   take;

   pc_target_calc u_tgt (
      .branch_ctrl (branch_ctrl),
      .ex_pc       (ex_pc),
      .ex_imm      (ex_imm),
      .jalr_target (jalr_target),
      .tgt         (tgt)
   );

   // EX holds only reset bubbles in BOOT, so a redirect there is meaningless.
   assign take = !rst && ex_valid && is_redirect(branch_ctrl) && (state != BOOT);

   always_ff @(posedge clk) begin
      if (rst) state <= BOOT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:    state_nxt = RUN;
         RUN:     if (!take && !hazard_stall && !imem_ready) state_nxt = WAIT;
         WAIT:    if (take || imem_ready) state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
   end

   always_comb begin
      imem_req     = 1'b0;
      pc_write     = 1'b0;
      flush_ifid   = take;
      flush_idex   = take;
      misalign_err = take && tgt.misalign;
      if (!rst) begin
         case (state)
            RUN: begin
               imem_req = 1'b1;
               pc_write = take || (!hazard_stall && imem_ready);
            end
            WAIT: begin
               imem_req = 1'b1;
               pc_write = take;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)           pc <= RESET_PC;
      else if (take)     pc <= tgt.target;
      else if (pc_write) pc <= pc + PC_STEP;
   end

   always_ff @(posedge clk) begin
      if (rst)
         redirect_cnt <= '0;
      else if (take && (redirect_cnt != {CNT_W{1'b1}}))
         redirect_cnt <= redirect_cnt + 1'b1;
   end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios plus a random
// run, all compared against a cycle-level behavioural model.
module tb_pc_redirect_ctrl;

   localparam int          CNT_W = 3;
   localparam int          CMAX  = (1 << CNT_W) - 1;
   localparam logic [39:0] MSK_RST = {32'h0, 5'b11111, 3'b000};

   logic             clk, rst;
   logic [1:0]       branch_ctrl;
   logic             ex_valid, hazard_stall, imem_ready;
   logic [31:0]      ex_pc, ex_imm, jalr_target;
   logic [31:0]      pc;
   logic             imem_req, pc_write, flush_ifid, flush_idex, misalign_err;
   logic [CNT_W-1:0] redirect_cnt;

   int total = 0;
   int bad   = 0;

   // Model state: current pc, counter, "first cycle after reset", "waiting on imem".
   logic [31:0] m_pc   = 32'h0;
   int          m_cnt  = 0;
   bit          m_boot = 1'b1;
   bit          m_wait = 1'b0;

   pc_redirect_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .branch_ctrl(branch_ctrl), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_imm(ex_imm), .jalr_target(jalr_target),
      .hazard_stall(hazard_stall), .imem_ready(imem_ready), .pc(pc),
      .imem_req(imem_req), .pc_write(pc_write), .flush_ifid(flush_ifid),
      .flush_idex(flush_idex), .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   wire [39:0] obs = {pc, imem_req, pc_write, flush_ifid, flush_idex, misalign_err, redirect_cnt};

   function automatic bit m_take();
      return !rst && !m_boot && ex_valid && (branch_ctrl == 2'd1 || branch_ctrl == 2'd2);
   endfunction

   function automatic logic [31:0] m_tgt();
      return (branch_ctrl == 2'd1) ? ex_pc + ex_imm : jalr_target & 32'hFFFF_FFFE;
   endfunction

   function automatic logic [39:0] exp_vec();
      bit t, adv;
      t   = m_take();
      adv = !rst && !m_boot && !m_wait && !hazard_stall && imem_ready;
      return {m_pc, !rst && !m_boot, t || adv, t, t, t && m_tgt()[1], m_cnt[CNT_W-1:0]};
   endfunction

   task automatic mdl_edge();
      if (rst) begin
         m_pc = 32'h0; m_cnt = 0; m_boot = 1'b1; m_wait = 1'b0;
      end else if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_take()) begin
         m_pc = m_tgt(); m_wait = 1'b0;
         if (m_cnt < CMAX) m_cnt = m_cnt + 1;
      end else if (m_wait) begin
         m_wait = !imem_ready;
      end else if (!hazard_stall) begin
         if (imem_ready) m_pc = m_pc + 32'd4;
         else            m_wait = 1'b1;
      end
   endtask

   task automatic set_in(input bit r, input logic [1:0] bc, input bit v,
                         input logic [31:0] epc, input logic [31:0] imm,
                         input logic [31:0] jt, input bit st, input bit rdy);
      rst = r; branch_ctrl = bc; ex_valid = v; ex_pc = epc; ex_imm = imm;
      jalr_target = jt; hazard_stall = st; imem_ready = rdy;
   endtask

   task automatic idle();
      set_in(0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0, 1);
   endtask

   task automatic adv();
      @(posedge clk);
      mdl_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [39:0] msk;
      for (int i = 0; i < 3; i++) begin
         set_in(1, 2'b01, 1, 32'h40, 32'h4, 32'h0, 0, 1);
         #1;
         total++;
         if ((obs & MSK_RST) !== (exp_vec() & MSK_RST)) begin
            bad++; $display("FAIL reset_hold: got=%h want=%h", obs & MSK_RST, exp_vec() & MSK_RST);
         end
         adv();
      end
      // Redirect offered in BOOT must be ignored.
      set_in(0, 2'b01, 1, 32'h100, 32'h100, 32'h0, 0, 1);
      #1;
      total++;
      if (pc !== 32'h0 || imem_req !== 1'b0 || flush_ifid !== 1'b0 || redirect_cnt !== '0) begin
         bad++; $display("FAIL boot_cycle: pc=%h req=%b flush=%b cnt=%0d want pc=0 req=0 flush=0 cnt=0",
                         pc, imem_req, flush_ifid, redirect_cnt);
      end
      adv();
      for (int k = 0; k < 4; k++) begin
         idle();
         #1;
         msk = '1;
         total++;
         if ((obs & msk) !== exp_vec() || pc !== 32'(4 * k) || imem_req !== 1'b1) begin
            bad++; $display("FAIL reset_seq%0d: got=%h want=%h (pc want %h)", k, obs, exp_vec(), 4 * k);
         end
         adv();
      end
   endtask

   task automatic test_branch();
      for (int i = 0; i < 16 && m_pc != 32'h20; i++) begin
         idle(); #1;
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL branch_walk: got=%h want=%h", obs, exp_vec());
         end
         adv();
      end
      set_in(0, 2'b01, 1, 32'h18, 32'hFFFF_FFF0, 32'h0, 0, 1);
      #1;
      total++;
      if (obs !== exp_vec() || pc !== 32'h20 || flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
         bad++; $display("FAIL branch_take: got=%h want=%h", obs, exp_vec());
      end
      adv(); idle(); #1;
      total++;
      if (pc !== 32'h08 || redirect_cnt !== 3'd1 || flush_ifid !== 1'b0) begin
         bad++; $display("FAIL branch_target: pc=%h cnt=%0d want pc=00000008 cnt=1", pc, redirect_cnt);
      end
   endtask

   task automatic test_jalr();
      set_in(0, 2'b10, 1, 32'h0, 32'h0, 32'h0000_1003, 0, 1);
      #1;
      total++;
      if (obs !== exp_vec() || misalign_err !== 1'b1) begin
         bad++; $display("FAIL jalr_take: got=%h want=%h", obs, exp_vec());
      end
      adv(); idle(); #1;
      total++;
      if (pc !== 32'h0000_1002 || misalign_err !== 1'b0 || obs !== exp_vec()) begin
         bad++; $display("FAIL jalr_target: pc=%h mis=%b want pc=00001002 mis=0", pc, misalign_err);
      end
   endtask

   task automatic test_stall();
      set_in(0, 2'b10, 1, 32'h0, 32'h0, 32'h40, 0, 1);
      adv();
      set_in(0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 1, 1);
      #1;
      total++;
      if (obs !== exp_vec() || pc !== 32'h40 || pc_write !== 1'b0 || flush_ifid !== 1'b0 || imem_req !== 1'b1) begin
         bad++; $display("FAIL stall_hold: got=%h want=%h", obs, exp_vec());
      end
      adv();
      set_in(0, 2'b01, 1, 32'h38, 32'h100, 32'h0, 1, 1);
      #1;
      total++;
      if (obs !== exp_vec() || pc !== 32'h40 || flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
         bad++; $display("FAIL stall_take: got=%h want=%h", obs, exp_vec());
      end
      adv(); idle(); #1;
      total++;
      if (pc !== 32'h138 || obs !== exp_vec()) begin
         bad++; $display("FAIL stall_target: pc=%h want 00000138", pc);
      end
   endtask

   task automatic test_backpressure();
      bit seen;
      set_in(0, 2'b10, 1, 32'h0, 32'h0, 32'h10, 0, 1);
      adv();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0, 0);
         #1;
         total++;
         if (obs !== exp_vec() || pc !== 32'h10 || imem_req !== 1'b1 || pc_write !== 1'b0) begin
            bad++; $display("FAIL bp_hold%0d: got=%h want=%h", i, obs, exp_vec());
         end
         adv();
      end
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idle(); #1;
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL bp_resume%0d: got=%h want=%h", i, obs, exp_vec());
         end
         if (pc === 32'h14) seen = 1'b1;
         adv();
      end
      total++;
      if (!seen) begin
         bad++; $display("FAIL bp_advance: pc never reached 00000014 (last %h)", pc);
      end
      // Redirect in the middle of a WAIT period while memory is still busy.
      for (int i = 0; i < 2; i++) begin
         set_in(0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0, 0); adv();
      end
      set_in(0, 2'b01, 1, 32'h100, 32'h20, 32'h0, 0, 0);
      #1;
      total++;
      if (obs !== exp_vec() || flush_ifid !== 1'b1 || pc_write !== 1'b1) begin
         bad++; $display("FAIL bp_wait_take: got=%h want=%h", obs, exp_vec());
      end
      adv();
      set_in(0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0, 0);
      #1;
      total++;
      if (pc !== 32'h120 || imem_req !== 1'b1 || obs !== exp_vec()) begin
         bad++; $display("FAIL bp_wait_target: pc=%h want 00000120", pc);
      end
      adv();
   endtask

   task automatic test_back_to_back();
      set_in(0, 2'b10, 1, 32'h0, 32'h0, 32'h200, 0, 1);
      adv();
      set_in(0, 2'b01, 1, 32'h300, 32'h4, 32'h0, 0, 1);
      #1;
      total++;
      if (pc !== 32'h200 || flush_ifid !== 1'b1 || obs !== exp_vec()) begin
         bad++; $display("FAIL b2b_first: pc=%h flush=%b want pc=00000200 flush=1", pc, flush_ifid);
      end
      adv();
      set_in(0, 2'b10, 1, 32'h0, 32'h0, 32'h400, 0, 1);
      #1;
      total++;
      if (pc !== 32'h304 || obs !== exp_vec()) begin
         bad++; $display("FAIL b2b_second: pc=%h want 00000304", pc);
      end
      adv(); idle(); #1;
      total++;
      if (pc !== 32'h400 || redirect_cnt !== 3'(CMAX)) begin
         bad++; $display("FAIL cnt_saturate: pc=%h cnt=%0d want pc=00000400 cnt=%0d", pc, redirect_cnt, CMAX);
      end
   endtask

   task automatic test_ignored();
      logic [31:0]      p0;
      logic [CNT_W-1:0] c0;
      p0 = m_pc; c0 = m_cnt[CNT_W-1:0];
      set_in(0, 2'b11, 1, 32'h500, 32'h500, 32'h500, 0, 1);
      #1;
      total++;
      if (obs !== exp_vec() || flush_ifid !== 1'b0 || pc_write !== 1'b1) begin
         bad++; $display("FAIL ign_rsvd: got=%h want=%h", obs, exp_vec());
      end
      adv();
      set_in(0, 2'b01, 0, 32'h600, 32'h600, 32'h0, 0, 1);
      #1;
      total++;
      if (obs !== exp_vec() || pc !== p0 + 32'd4 || flush_idex !== 1'b0) begin
         bad++; $display("FAIL ign_invalid: got=%h want=%h", obs, exp_vec());
      end
      adv(); idle(); #1;
      total++;
      if (pc !== p0 + 32'd8 || redirect_cnt !== c0) begin
         bad++; $display("FAIL ign_result: pc=%h cnt=%0d want pc=%h cnt=%0d", pc, redirect_cnt, p0 + 32'd8, c0);
      end
   endtask

   task automatic test_random();
      logic [39:0] msk;
      for (int i = 0; i < 600; i++) begin
         set_in($urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
         #1;
         msk = rst ? MSK_RST : '1;
         total++;
         if ((obs & msk) !== (exp_vec() & msk)) begin
            bad++; $display("FAIL random%0d: got=%h want=%h", i, obs & msk, exp_vec() & msk);
         end
         adv();
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_branch();
      test_jalr();
      test_stall();
      test_backpressure();
      test_back_to_back();
      test_ignored();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
